// File: rtl/stream_merge_pkg.sv
// Shared lane/word types and the lane-pairing helper for the stream merger.
package stream_merge_pkg;

  localparam int LANE_W = 32;
  localparam int WORD_W = 64;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [WORD_W-1:0] word_t;

  // Lane 0 forms the lower half of the merged word, lane 1 the upper half.
  function automatic word_t merge(input lane_t lo, input lane_t hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single-lane synchronous FIFO with registered full/empty flags and
// occupancy; the head entry is visible without a read cycle so a pop can
// happen the cycle after the first write.
module lane_fifo
  import stream_merge_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  lane_t                  i_wr_data,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic                   i_rd_en,
  output lane_t                  o_head,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  lane_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          r_full;
  logic          r_empty;
  logic          w_wr_en;
  logic          w_rd_en;

  // Ready comes only from the registered full flag and is held low in reset.
  assign o_wr_ready = !r_full && !rst;
  assign w_wr_en    = i_wr_valid && !r_full && !rst;
  assign w_rd_en    = i_rd_en && !r_empty;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;
  assign o_count = r_count;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage array; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, occupancy and flags; reset discards any buffered content.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

endmodule

// File: rtl/stream_lane_merger.sv
// Re-pairs two 32-bit lane streams into 64-bit AXI-Stream words, marks the
// last word of each frame, counts frames and flags lane divergence.
module stream_lane_merger
  import stream_merge_pkg::*;
#(
  parameter int TOTAL_SAMPLES = 3276,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   s0_tdata,
  input  logic          s0_tvalid,
  output logic          s0_tready,
  input  logic [31:0]   s1_tdata,
  input  logic          s1_tvalid,
  output logic          s1_tready,
  output logic [63:0]   m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          skew_err
);

  localparam int CW = $clog2(TOTAL_SAMPLES);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL_SAMPLES - 1);

  lane_t           w_lane_data  [2];
  lane_t           w_head       [2];
  logic [NW-1:0]   w_count      [2];
  logic [1:0]      w_lane_valid;
  logic [1:0]      w_lane_ready;
  logic [1:0]      w_empty;
  logic [1:0]      w_full;

  word_t           r_m_tdata;
  logic            r_m_tvalid;
  logic            r_m_tlast;
  logic [CW-1:0]   r_word_cnt;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_load_idx;
  logic            r_frame_done;
  logic [15:0]     r_frame_count;
  logic            r_skew_err;
  logic            w_pop;
  logic            w_hs;
  logic            w_skew;

  assign w_lane_data[0]  = s0_tdata;
  assign w_lane_data[1]  = s1_tdata;
  assign w_lane_valid    = {s1_tvalid, s0_tvalid};
  assign s0_tready       = w_lane_ready[0];
  assign s1_tready       = w_lane_ready[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_data  (w_lane_data[gi]),
        .i_wr_valid (w_lane_valid[gi]),
        .o_wr_ready (w_lane_ready[gi]),
        .i_rd_en    (w_pop),
        .o_head     (w_head[gi]),
        .o_empty    (w_empty[gi]),
        .o_full     (w_full[gi]),
        .o_count    (w_count[gi])
      );
    end
  endgenerate

  // Both lanes pop together, so pairing is exact regardless of skew.
  assign w_pop = !w_empty[0] && !w_empty[1] && (!r_m_tvalid || m_tready);
  assign w_hs  = r_m_tvalid && m_tready;

  // Index of a word being loaded: if the register still holds a word, that
  // word is leaving on this edge, so the new one is the next index.
  assign w_cnt_inc  = (r_word_cnt == LAST_IDX) ? '0 : r_word_cnt + 1'b1;
  assign w_load_idx = r_m_tvalid ? w_cnt_inc : r_word_cnt;

  // One lane completely full while the other is empty means divergence.
  assign w_skew = (w_full[0] && (w_count[1] == '0)) ||
                  (w_full[1] && (w_count[0] == '0));

  assign m_tdata     = r_m_tdata;
  assign m_tvalid    = r_m_tvalid;
  assign m_tlast     = r_m_tlast;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign skew_err    = r_skew_err;

  // Output register: loads on a pop, holds while stalled, empties on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_pop) begin
      r_m_tdata  <= merge(w_head[0], w_head[1]);
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= (w_load_idx == LAST_IDX);
    end else if (w_hs) begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end
  end

  // Word index within the frame, advanced by output handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
    end else if (w_hs) begin
      r_word_cnt <= w_cnt_inc;
    end
  end

  // Frame completion pulse and wrapping frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_done <= w_hs && r_m_tlast;
      if (w_hs && r_m_tlast) r_frame_count <= r_frame_count + 1'b1;
    end
  end

  // Sticky skew fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skew_err <= 1'b0;
    end else if (w_skew) begin
      r_skew_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_lane_merger.sv
// Randomised bench for stream_lane_merger against a queue-based lane model.
module tb_stream_lane_merger;

  localparam int T = 3276;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s0_tdata = '0;
  logic        s0_tvalid = 1'b0;
  logic        s0_tready;
  logic [31:0] s1_tdata = '0;
  logic        s1_tvalid = 1'b0;
  logic        s1_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        skew_err;

  stream_lane_merger #(.TOTAL_SAMPLES(T), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s0_tdata    (s0_tdata),
    .s0_tvalid   (s0_tvalid),
    .s0_tready   (s0_tready),
    .s1_tdata    (s1_tdata),
    .s1_tvalid   (s1_tvalid),
    .s1_tready   (s1_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .skew_err    (skew_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: accepted lane words, word index, frame count.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  int          widx = 0;
  logic [15:0] fcount = '0;
  logic        pend_done = 1'b0;
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Stimulus state.
  int          cyc = 0;
  int          rem0, rem1, start0, start1, sent0, sent1;
  logic [31:0] base0, base1;
  logic        rdy_rand = 1'b0;

  // Scenario observations.
  int   n_hs, n_done, first_acc0, first_acc1, first_valid, first_hs, last_hs;
  int   last_tlast_at;
  logic saw_low0, saw_low1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic setup(input int n0, input int st0, input logic [31:0] b0,
                       input int n1, input int st1, input logic [31:0] b1);
    rem0 = n0; start0 = cyc + st0; base0 = b0; sent0 = 0;
    rem1 = n1; start1 = cyc + st1; base1 = b1; sent1 = 0;
    n_hs = 0; n_done = 0; first_acc0 = -1; first_acc1 = -1;
    first_valid = -1; first_hs = -1; last_hs = -1; last_tlast_at = -1;
    saw_low0 = 1'b0; saw_low1 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    chk("rst_s0_tready", 64'(s0_tready), 0);
    chk("rst_s1_tready", 64'(s1_tready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq0.delete(); mq1.delete();
    widx = 0; fcount = '0; pend_done = 1'b0; stall_prev = 1'b0;
    rem0 = 0; rem1 = 0;
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 0);
    chk("rst_m_tlast", 64'(m_tlast), 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_frame_done", 64'(frame_done), 0);
    chk("rst_frame_count", 64'(frame_count), 0);
    chk("rst_skew_err", 64'(skew_err), 0);
    chk("post_rst_s0_tready", 64'(s0_tready), 1);
    chk("post_rst_s1_tready", 64'(s1_tready), 1);
  endtask

  // One clock cycle: drive, sample mid-cycle, update model, advance.
  task automatic cycle_step();
    logic        a0, a1, hs;
    logic [31:0] lo, hi;
    s0_tvalid = (rem0 > 0) && (cyc >= start0);
    s0_tdata  = base0 + 32'(sent0);
    s1_tvalid = (rem1 > 0) && (cyc >= start1);
    s1_tdata  = base1 + 32'(sent1);
    m_tready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    a0 = s0_tvalid && s0_tready;
    a1 = s1_tvalid && s1_tready;
    hs = m_tvalid && m_tready;
    if (stall_prev) begin
      chk("hold_valid", 64'(m_tvalid), 1);
      chk("hold_data", m_tdata, prev_data);
      chk("hold_last", 64'(m_tlast), 64'(prev_last));
    end
    chk("frame_done", 64'(frame_done), 64'(pend_done));
    chk("frame_count", 64'(frame_count), 64'(fcount));
    if (frame_done) n_done++;
    if (m_tvalid && first_valid < 0) first_valid = cyc;
    if (!s0_tready) saw_low0 = 1'b1;
    if (!s1_tready) saw_low1 = 1'b1;
    pend_done = 1'b0;
    if (hs) begin
      n_hs++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      chk("word_available", 64'(mq0.size() > 0 && mq1.size() > 0), 1);
      if (mq0.size() > 0 && mq1.size() > 0) begin
        lo = mq0.pop_front();
        hi = mq1.pop_front();
        chk("m_tdata", m_tdata, {hi, lo});
        chk("m_tlast", 64'(m_tlast), 64'(widx == T - 1));
        if (m_tlast) last_tlast_at = n_hs;
        if (widx == T - 1) begin
          widx = 0;
          pend_done = 1'b1;
          fcount = fcount + 16'd1;
        end else begin
          widx++;
        end
      end
    end
    stall_prev = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (a0) begin
      mq0.push_back(s0_tdata); sent0++; rem0--;
      if (first_acc0 < 0) first_acc0 = cyc;
    end
    if (a1) begin
      mq1.push_back(s1_tdata); sent1++; rem1--;
      if (first_acc1 < 0) first_acc1 = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int fw_done;
    do_reset();

    // Aligned stream.
    rdy_rand = 1'b0;
    setup(T, 0, 32'h0000_0000, T, 0, 32'h8000_0000);
    repeat (T + 10) cycle_step();
    chk("aligned_words", 64'(n_hs), 64'(T));
    chk("aligned_latency", 64'(first_valid - first_acc1), 2);
    chk("aligned_rate", 64'(last_hs - first_hs), 64'(T - 1));
    chk("aligned_tlast_pos", 64'(last_tlast_at), 64'(T));
    chk("aligned_done_pulses", 64'(n_done), 1);
    chk("aligned_frame_count", 64'(frame_count), 1);
    chk("aligned_skew", 64'(skew_err), 0);
    $display("aligned: %0d words, %0d frame_done pulses", n_hs, n_done);

    // Skewed lanes: lane 1 ten cycles late.
    setup(T, 0, 32'h0000_0000, T, 10, 32'h8000_0000);
    repeat (T + 25) cycle_step();
    chk("skew_words", 64'(n_hs), 64'(T));
    chk("skew_latency", 64'(first_valid - first_acc1), 2);
    chk("skew_lane1_delay", 64'(first_acc1 - first_acc0), 10);
    chk("skew_done_pulses", 64'(n_done), 1);
    chk("skew_err_clear", 64'(skew_err), 0);
    $display("skewed: %0d words, lane1 first accept +%0d", n_hs, first_acc1 - first_acc0);

    // Skew overflow: lane 0 alone, then lane 1 catches up.
    setup(20, 0, 32'h0000_1000, 0, 0, 32'h9000_0000);
    repeat (30) cycle_step();
    chk("ovf_accepts", 64'(sent0), 16);
    chk("ovf_s0_tready", 64'(s0_tready), 0);
    chk("ovf_skew_set", 64'(skew_err), 1);
    chk("ovf_no_valid", 64'(first_valid), 64'(-1));
    rem1 = 20; start1 = cyc;
    repeat (45) cycle_step();
    chk("ovf_words", 64'(n_hs), 20);
    chk("ovf_lane0_drained", 64'(mq0.size()), 0);
    chk("ovf_skew_sticky", 64'(skew_err), 1);
    $display("overflow: %0d lane0 accepts before stall, %0d words out", 16, n_hs);

    // Output back-pressure with random m_tready.
    do_reset();
    rdy_rand = 1'b1;
    setup(600, 0, $urandom, 600, 0, $urandom);
    repeat (2000) cycle_step();
    rdy_rand = 1'b0;
    chk("bp_words", 64'(n_hs), 600);
    chk("bp_lane0_drained", 64'(mq0.size()), 0);
    chk("bp_lane1_drained", 64'(mq1.size()), 0);
    chk("bp_s0_ready_dropped", 64'(saw_low0), 1);
    chk("bp_s1_ready_dropped", 64'(saw_low1), 1);
    $display("backpressure: %0d words", n_hs);

    // Reset mid-frame, then one full frame.
    do_reset();
    setup(T, 0, 32'h1111_0000, T, 0, 32'h2222_0000);
    for (int k = 0; k < 1100 && n_hs < 1000; k++) cycle_step();
    chk("midrst_words_before", 64'(n_hs), 1000);
    do_reset();
    setup(T, 0, 32'h3333_0000, T, 0, 32'h4444_0000);
    repeat (T + 10) cycle_step();
    chk("midrst_words", 64'(n_hs), 64'(T));
    chk("midrst_tlast_pos", 64'(last_tlast_at), 64'(T));
    chk("midrst_frame_count", 64'(frame_count), 1);
    $display("reset mid-frame: next frame %0d words, tlast at word %0d", n_hs, last_tlast_at);

    // Three frames with idle gaps between them.
    do_reset();
    fw_done = 0;
    for (int f = 0; f < 3; f++) begin
      setup(T, 0, 32'(f) << 24, T, 0, (32'(f) << 24) | 32'h8000_0000);
      repeat (T + 6) cycle_step();
      repeat (1172) cycle_step();
      fw_done += n_done;
      chk("wrap_frame_count", 64'(frame_count), 64'(f + 1));
      chk("wrap_tlast_pos", 64'(last_tlast_at), 64'(T));
    end
    chk("wrap_done_pulses", 64'(fw_done), 3);
    $display("frame wrap: frame_count=%0d, %0d frame_done pulses", frame_count, fw_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
